// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
// Buffered 8N1 UART transmitter: a circular byte FIFO feeding a serializer
// with a divider that is latched once per frame.
//   state | meaning
//   IDLE  | line high, waiting for a byte in the FIFO
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit (high); pops the next byte at its end if one is queued
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   cfg_divider,
  input  logic [7:0]    data,
  input  logic          valid,
  output logic          ready,
  output logic          ser_tx,
  output logic          busy,
  output logic [LW-1:0] level
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [31:0]   baud_cnt;
  logic [31:0]   div_q;
  logic [31:0]   div_next;
  logic          push;
  logic          pop;
  logic          bit_end;

  assign ready    = (level != LW'(DEPTH));
  assign busy     = (state != IDLE) || (level != '0);
  assign push     = valid && ready;
  assign bit_end  = (baud_cnt == div_q - 32'd1);
  assign pop      = (level != '0) && ((state == IDLE) || ((state == STOP) && bit_end));
  // Divider values below 2 would leave no room for the counter to run.
  assign div_next = (cfg_divider < 32'd2) ? 32'd2 : cfg_divider;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ser_tx   <= 1'b1;
      shreg    <= '0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      div_q    <= 32'd2;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shreg    <= mem[rd_ptr];
            div_q    <= div_next;
            baud_cnt <= '0;
            ser_tx   <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            ser_tx   <= shreg[0];
            shreg    <= shreg >> 1;
            bit_cnt  <= '0;
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              ser_tx <= 1'b1;
              state  <= STOP;
            end else begin
              ser_tx  <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (pop) begin
              // Back-to-back frame: no idle cycle between stop and start.
              shreg  <= mem[rd_ptr];
              div_q  <= div_next;
              ser_tx <= 1'b0;
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
// Bench for uart_tx_fifo: a queue-based frame-timing model checks every cycle,
// plus table-driven single frames and hand-written multi-cycle sequences.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int LW    = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   cfg_divider = 32'd217;
  logic [7:0]    data = 8'h00;
  logic          valid = 1'b0;
  logic          ready;
  logic          ser_tx;
  logic          busy;
  logic [LW-1:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk(clk), .reset(reset), .cfg_divider(cfg_divider), .data(data),
    .valid(valid), .ready(ready), .ser_tx(ser_tx), .busy(busy), .level(level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, the current frame as
  // (start cycle, bit period, byte); the line value follows from arithmetic.
  logic [7:0] mq[$];
  bit         m_in = 0;
  longint     m_cyc = 0;
  longint     m_fstart = 0;
  int         m_fd = 2;
  logic [7:0] m_fb = 8'h00;

  initial begin : model
    int  pre_sz;
    bit  pre_in, endf;
    int  k;
    logic exp_tx;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_in = 0;
      end else begin
        m_cyc++;
        pre_sz = mq.size();
        pre_in = m_in;
        endf   = m_in && ((m_cyc - m_fstart) == 10 * m_fd);
        if (endf) m_in = 0;
        if ((!pre_in || endf) && pre_sz > 0) begin
          m_fb     = mq.pop_front();
          m_in     = 1;
          m_fstart = m_cyc;
          m_fd     = (cfg_divider < 2) ? 2 : int'(cfg_divider);
        end
        if (valid && pre_sz < DEPTH) mq.push_back(data);
      end
      #1;
      exp_tx = 1'b1;
      if (m_in) begin
        k = int'((m_cyc - m_fstart) / m_fd);
        if (k == 0) exp_tx = 1'b0;
        else if (k <= 8) exp_tx = m_fb[k-1];
      end
      check("model_ser_tx", ser_tx, exp_tx);
      check("model_level", level, mq.size());
      check("model_ready", ready, mq.size() != DEPTH);
      check("model_busy", busy, m_in || mq.size() != 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] b);
    int w;
    @(negedge clk);
    data  = b;
    valid = 1'b1;
    for (w = 0; !ready && w < 1000; w++) @(negedge clk);
    check("push_ready_wait", ready, 1'b1);
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    for (c = 0; busy && c < 5000; c++) tick();
    check("wait_idle_timeout", busy, 1'b0);
  endtask

  typedef struct {
    logic [31:0] div;
    logic [7:0]  b;
    int          d;
  } vec_t;

  vec_t tbl[5];

  task automatic run_vec(input vec_t v);
    logic [7:0] got;
    int d;
    d = v.d;
    got = 8'h00;
    cfg_divider = v.div;
    push_one(v.b);
    check("tbl_level_after_push", level, 1);
    check("tbl_line_idle_at_accept", ser_tx, 1'b1);
    for (int t = 1; t <= 10 * d + 1; t++) begin
      tick();
      if (t == 1)     check("tbl_start_fall", ser_tx, 1'b0);
      if (t == d)     check("tbl_start_last_cycle", ser_tx, 1'b0);
      for (int k = 1; k <= 8; k++)
        if (t == 1 + k * d + d / 2) got[k-1] = ser_tx;
      if (t == 1 + 9 * d + d / 2) check("tbl_stop_bit", ser_tx, 1'b1);
      if (t == 10 * d)     check("tbl_busy_last", busy, 1'b1);
      if (t == 10 * d + 1) check("tbl_busy_drop", busy, 1'b0);
    end
    check("tbl_byte", got, v.b);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int t, n, c, lows, busies;
    bit acc;

    tbl[0] = '{div: 32'd217, b: 8'h41, d: 217};
    tbl[1] = '{div: 32'd0,   b: 8'hFF, d: 2};
    tbl[2] = '{div: 32'd1,   b: 8'h5A, d: 2};
    tbl[3] = '{div: 32'd3,   b: 8'hA5, d: 3};
    tbl[4] = '{div: 32'd8,   b: 8'h00, d: 8};

    repeat (3) @(posedge clk);
    #1;
    check("reset_ser_tx", ser_tx, 1'b1);
    check("reset_level", level, 0);
    check("reset_ready", ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_reset_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Burst fill at d=4 with valid held high.
    wait_idle();
    @(negedge clk);
    cfg_divider = 32'd4;
    data  = 8'h00;
    valid = 1'b1;
    n = 0;
    t = -1;
    for (c = 0; c < 2000 && n < 18; c++) begin
      acc = ready;
      @(posedge clk);
      #1;
      t++;
      if (acc) begin
        n++;
        if (n == 17) begin
          check("burst_full_level", level, 16);
          check("burst_full_ready", ready, 1'b0);
        end
        if (n == 18) check("burst_last_accept_time", t, 42);
        data = 8'(n);
      end
      if (n == 18) valid = 1'b0;
      @(negedge clk);
    end
    check("burst_all_accepted", n, 18);
    for (c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      t++;
      if (!busy) break;
    end
    check("burst_end_time", t, 721);

    // Simultaneous push and pop on the STOP->START edge with level=3.
    wait_idle();
    cfg_divider = 32'd4;
    push_one(8'h11);
    t = 0;
    push_one(8'h22); t++;
    push_one(8'h33); t++;
    push_one(8'h44); t++;
    while (t < 40) begin tick(); t++; end
    check("simul_level_before", level, 3);
    @(negedge clk);
    data  = 8'h55;
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check("simul_level_after", level, 3);
    check("simul_new_start", ser_tx, 1'b0);

    // Divider change mid-frame only affects the following frame.
    wait_idle();
    cfg_divider = 32'd8;
    push_one(8'h3C);
    t = 0;
    push_one(8'h01); t++;
    while (t < 241) begin
      tick();
      t++;
      if (t == 30) cfg_divider = 32'd16;
      if (t == 80)  check("div_first_stop", ser_tx, 1'b1);
      if (t == 81)  check("div_second_start", ser_tx, 1'b0);
      if (t == 96)  check("div_second_start_len", ser_tx, 1'b0);
      if (t == 97)  check("div_second_bit0", ser_tx, 1'b1);
      if (t == 240) check("div_busy_last", busy, 1'b1);
      if (t == 241) check("div_busy_drop", busy, 1'b0);
    end

    // Reset during data bit 3 with bytes queued.
    wait_idle();
    cfg_divider = 32'd8;
    push_one(8'h00);
    t = 0;
    for (int i = 1; i < 5; i++) begin push_one(8'(8'hA0 + i)); t++; end
    while (t < 36) begin tick(); t++; end
    check("rst_mid_line_low", ser_tx, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_ser_tx", ser_tx, 1'b1);
    check("rst_async_level", level, 0);
    check("rst_async_busy", busy, 1'b0);
    check("rst_async_ready", ready, 1'b1);
    repeat (2) tick();
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    busies = 0;
    repeat (150) begin
      tick();
      if (!ser_tx) lows++;
      if (busy) busies++;
    end
    check("rst_no_frames_after", lows, 0);
    check("rst_stays_idle", busies, 0);
    cfg_divider = 32'd3;
    push_one(8'h96);
    wait_idle();

    // Randomised traffic, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      valid = ($urandom_range(0, 9) < 7);
      data  = 8'($urandom);
      if ($urandom_range(0, 99) == 0) cfg_divider = $urandom_range(0, 6);
    end
    @(negedge clk);
    valid = 1'b0;
    for (c = 0; busy && c < 20000; c++) tick();
    check("random_drain", busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
